imu_spi_seq: RTL and testbench
==============================

Name: imu_spi_seq

Overview:
- Sequencer for the SPI monarch serial engine. Owns its wrt/wrt_data/done/rd_data handshake to configure an inertial sensor after power-up, then services its data-ready interrupt.
- On each interrupt it reads the yaw-rate low and high bytes and presents one assembled 16-bit sample with a single-cycle valid strobe.
- Sits between the SPI monarch instance and the heading/navigation logic.

Parameters:
- PWR_DLY_W, 16, width of power-up delay counter; init starts when counter reaches all-ones (2^PWR_DLY_W - 1 cycles after reset release).
- INIT_WR0, 16'h0D02, first config frame (interrupt-on-data-ready enable).
- INIT_WR1, 16'h1160, second config frame (accel ODR/range).
- INIT_WR2, 16'h1440, third config frame (gyro ODR/range).
- RD_YAW_L, 16'hA600, read frame for yaw low byte (bit15=1 read, [14:8] addr, [7:0] don't-care).
- RD_YAW_H, 16'hA700, read frame for yaw high byte.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- INT  in  1  sensor data-ready interrupt, asynchronous, active-high level
- spi_done  in  1  done level from SPI monarch (high after transaction, cleared when next starts)
- spi_rd_data  in  16  word shifted in by SPI monarch
- spi_wrt  out  1  one-cycle start pulse to SPI monarch
- spi_wrt_data  out  16  frame to transmit; valid in the spi_wrt cycle
- yaw_rt  out  16  signed yaw rate {high byte, low byte}
- vld  out  1  one-cycle strobe, yaw_rt updated
- init_done  out  1  level, high once all three config writes completed

Behaviour:
- Reset values: spi_wrt=0, spi_wrt_data=0, yaw_rt=0, vld=0, init_done=0, state=PWR_WAIT, delay counter=0, INT synchronizer=0, low-byte holding register=0.
- INT passes through a 2-flop synchronizer before use. It is level-sensed; no edge detect.
- Completion is the rising edge of spi_done: done_q registered, fire = spi_done & ~done_q. A stale high spi_done from the previous frame must never count as completion.
- States (registered next-state logic, one always_comb):
  - PWR_WAIT: count each cycle. At all-ones -> INIT0 and pulse wrt with INIT_WR0.
  - INIT0 / INIT1 / INIT2: wait for fire. On fire issue the next frame with a wrt pulse in the same cycle. On fire in INIT2 -> set init_done (sticky until reset) -> WAIT_INT.
  - WAIT_INT: when synced INT=1, pulse wrt with RD_YAW_L -> RD_L.
  - RD_L: on fire, latch spi_rd_data[7:0] into the low register, pulse wrt with RD_YAW_H -> RD_H.
  - RD_H: on fire, yaw_rt <= {spi_rd_data[7:0], low_reg}; vld=1 for exactly that clock -> WAIT_INT.
- spi_wrt is asserted for exactly one cycle per frame and never while a frame is outstanding.
- Latency: from synced INT high to vld = 2 SPI frames + 2 cycles.
- INT still high on return to WAIT_INT: start the next read pair immediately, with no extra idle cycle.
- INT deasserting mid-read: the current read pair still completes.
- Reset asserted mid-frame: all state clears immediately. The power-up delay reruns in full. Any SPI frame in flight is abandoned; its later spi_done rise is ignored unless a frame has been issued since.
- vld and spi_wrt never coincide with reset.

Optional Feature:
- Macro: IMU_INT_TIMEOUT_EN.
- Defined: adds a 20-bit watchdog counter and output port int_to (1 bit, reset 0).
  - Counter clears on entry to WAIT_INT and counts while waiting.
  - At all-ones it sets int_to sticky and forces a read pair as if INT were high.
  - int_to clears on the next genuine synced INT.
- Not defined: no counter, no port. WAIT_INT waits indefinitely.

Decomposition:
- Package imu_spi_pkg holds:
  - state enum imu_state_t (PWR_WAIT, INIT0, INIT1, INIT2, WAIT_INT, RD_L, RD_H), 3-bit
  - frame constants: default config/read words, read bit position 15
- Sub-module imu_int_sync: 2-flop synchronizer with asynchronous active-high reset; reused elsewhere for other async inputs.

Test Plan:
- Reset, PWR_DLY_W=4; model spi_done rising 40 cycles after each wrt -> wrt at cycle 15 with 16'h0D02, then 16'h1160, 16'h1440; init_done rises on third done edge; exactly 3 wrt pulses.
- After init, INT=1 for 2 cycles; model returns 16'h00B4 then 16'h00FF -> wrt data 16'hA600 then 16'hA700, yaw_rt=16'hFFB4, vld high exactly 1 cycle.
- Hold spi_done high across wrt (stale level) -> no advance until done falls and rises again.
- INT held high continuously -> back-to-back read pairs; vld pulses every 2 frames + 2 cycles; no idle cycle between pairs.
- rst asserted during RD_H -> all outputs 0 at once; init_done=0; init sequence repeats after full delay; late done pulse ignored.
- (IMU_INT_TIMEOUT_EN) INT held low past timeout -> int_to=1, forced read pair completes with vld; next real INT clears int_to.

Source files
------------

// File: rtl/imu_spi_pkg.sv
// Shared state encoding and default SPI frame words for the IMU sequencer.
package imu_spi_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT0,
    INIT1,
    INIT2,
    WAIT_INT,
    RD_L,
    RD_H
  } imu_state_t;

  localparam logic [15:0] DEF_INIT_WR0 = 16'h0D02;
  localparam logic [15:0] DEF_INIT_WR1 = 16'h1160;
  localparam logic [15:0] DEF_INIT_WR2 = 16'h1440;
  localparam logic [15:0] DEF_RD_YAW_L = 16'hA600;
  localparam logic [15:0] DEF_RD_YAW_H = 16'hA700;
  localparam int          RD_BIT       = 15;

endpackage

// File: rtl/imu_int_sync.sv
// Two-flop synchronizer for a single asynchronous level input; 2-cycle latency.
module imu_int_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/imu_spi_seq.sv
// IMU bring-up and yaw-rate read sequencer driving an SPI monarch; vld lands 2 frames + 2 cycles after INT.
// Optional IMU_INT_TIMEOUT_EN adds a WAIT_INT watchdog with a sticky int_to output.
module imu_spi_seq
  import imu_spi_pkg::*;
#(
  parameter int          PWR_DLY_W = 16,
  parameter logic [15:0] INIT_WR0  = DEF_INIT_WR0,
  parameter logic [15:0] INIT_WR1  = DEF_INIT_WR1,
  parameter logic [15:0] INIT_WR2  = DEF_INIT_WR2,
  parameter logic [15:0] RD_YAW_L  = DEF_RD_YAW_L,
  parameter logic [15:0] RD_YAW_H  = DEF_RD_YAW_H
`ifdef IMU_INT_TIMEOUT_EN
  ,
  parameter int          TO_W      = 20
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        spi_done,
  input  logic [15:0] spi_rd_data,
  output logic        spi_wrt,
  output logic [15:0] spi_wrt_data,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        init_done
`ifdef IMU_INT_TIMEOUT_EN
  ,
  output logic        int_to
`endif
);

  imu_state_t           state, state_nxt;
  logic [PWR_DLY_W-1:0] dly_cnt;
  logic                 done_q;
  logic                 pend;
  logic                 int_s;
  logic                 fire;
  logic                 rd_req;
  logic [7:0]           low_reg, low_nxt;
  logic                 wrt_nxt, vld_nxt, init_nxt;
  logic [15:0]          dat_nxt, yaw_nxt;
  logic                 unused_rd_hi;

  // Only the low byte of a read frame carries register data.
  assign unused_rd_hi = ^spi_rd_data[15:8];

  imu_int_sync u_int_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (INT),
    .sync_out (int_s)
  );

  // A done rise only counts if a frame was issued since reset or the last accepted completion.
  assign fire = spi_done & ~done_q & pend;

`ifdef IMU_INT_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;

  assign to_hit = (state == WAIT_INT) && (&to_cnt);
  assign rd_req = int_s | to_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      int_to <= 1'b0;
    end else begin
      to_cnt <= (state == WAIT_INT) ? to_cnt + 1'b1 : '0;
      if (int_s)       int_to <= 1'b0;
      else if (to_hit) int_to <= 1'b1;
    end
  end
`else
  assign rd_req = int_s;
`endif

  always_comb begin
    state_nxt = state;
    wrt_nxt   = 1'b0;
    dat_nxt   = spi_wrt_data;
    vld_nxt   = 1'b0;
    yaw_nxt   = yaw_rt;
    low_nxt   = low_reg;
    init_nxt  = init_done;
    case (state)
      PWR_WAIT: if (&dly_cnt) begin
        state_nxt = INIT0; wrt_nxt = 1'b1; dat_nxt = INIT_WR0;
      end
      INIT0: if (fire) begin
        state_nxt = INIT1; wrt_nxt = 1'b1; dat_nxt = INIT_WR1;
      end
      INIT1: if (fire) begin
        state_nxt = INIT2; wrt_nxt = 1'b1; dat_nxt = INIT_WR2;
      end
      INIT2: if (fire) begin
        state_nxt = WAIT_INT; init_nxt = 1'b1;
      end
      WAIT_INT: if (rd_req) begin
        state_nxt = RD_L; wrt_nxt = 1'b1; dat_nxt = RD_YAW_L;
      end
      RD_L: if (fire) begin
        low_nxt   = spi_rd_data[7:0];
        state_nxt = RD_H; wrt_nxt = 1'b1; dat_nxt = RD_YAW_H;
      end
      RD_H: if (fire) begin
        yaw_nxt = {spi_rd_data[7:0], low_reg};
        vld_nxt = 1'b1;
        // Chain straight into the next pair while INT is still asserted.
        if (int_s) begin
          state_nxt = RD_L; wrt_nxt = 1'b1; dat_nxt = RD_YAW_L;
        end else begin
          state_nxt = WAIT_INT;
        end
      end
      default: state_nxt = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= PWR_WAIT;
      dly_cnt      <= '0;
      done_q       <= 1'b0;
      pend         <= 1'b0;
      low_reg      <= '0;
      spi_wrt      <= 1'b0;
      spi_wrt_data <= '0;
      yaw_rt       <= '0;
      vld          <= 1'b0;
      init_done    <= 1'b0;
    end else begin
      state        <= state_nxt;
      if (state == PWR_WAIT) dly_cnt <= dly_cnt + 1'b1;
      done_q       <= spi_done;
      if (wrt_nxt)   pend <= 1'b1;
      else if (fire) pend <= 1'b0;
      low_reg      <= low_nxt;
      spi_wrt      <= wrt_nxt;
      spi_wrt_data <= dat_nxt;
      yaw_rt       <= yaw_nxt;
      vld          <= vld_nxt;
      init_done    <= init_nxt;
    end
  end

endmodule

// File: tb/tb_imu_spi_seq.sv
// Directed bench for imu_spi_seq with a behavioural SPI monarch (done rises 40 cycles after each wrt).
module tb_imu_spi_seq;

  localparam int FRAME_LAT = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        INT = 1'b0;
  logic        spi_done = 1'b0;
  logic [15:0] spi_rd_data = 16'h0;
  logic        spi_wrt;
  logic [15:0] spi_wrt_data;
  logic [15:0] yaw_rt;
  logic        vld;
  logic        init_done;
`ifdef IMU_INT_TIMEOUT_EN
  logic        int_to;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  imu_spi_seq #(
    .PWR_DLY_W (4)
`ifdef IMU_INT_TIMEOUT_EN
    , .TO_W    (7)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .INT          (INT),
    .spi_done     (spi_done),
    .spi_rd_data  (spi_rd_data),
    .spi_wrt      (spi_wrt),
    .spi_wrt_data (spi_wrt_data),
    .yaw_rt       (yaw_rt),
    .vld          (vld),
    .init_done    (init_done)
`ifdef IMU_INT_TIMEOUT_EN
    , .int_to     (int_to)
`endif
  );

  always #5 clk = ~clk;

  // SPI monarch model: ignores reset, so an abandoned frame still completes later.
  int          age = 0;
  bit          busy = 1'b0;
  logic [15:0] frame = 16'h0;
  int          stale_hold = 0;
  logic [7:0]  lo_val = 8'h00, hi_val = 8'h00, upper = 8'h00;

  always @(posedge clk) begin
    if (spi_wrt) begin
      busy = 1'b1; age = 0; frame = spi_wrt_data;
    end else if (busy) begin
      age++;
    end
    if (busy) begin
      if (age == FRAME_LAT - 1) begin
        spi_done    <= 1'b1;
        spi_rd_data <= (frame == 16'hA600) ? {upper, lo_val} :
                       (frame == 16'hA700) ? {upper, hi_val} : 16'h0000;
        busy = 1'b0;
      end else if (age >= stale_hold) begin
        spi_done <= 1'b0;
      end
    end
  end

  int          wrt_idx[$];
  logic [15:0] wrt_dat[$];
  int          vld_idx[$];
  logic [15:0] vld_yaw[$];
  int          init_idx;

  task automatic run_cycles(input int n, input int int_off);
    wrt_idx.delete(); wrt_dat.delete(); vld_idx.delete(); vld_yaw.delete();
    init_idx = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (spi_wrt) begin wrt_idx.push_back(i); wrt_dat.push_back(spi_wrt_data); end
      if (vld) begin vld_idx.push_back(i); vld_yaw.push_back(yaw_rt); end
      if (init_done && init_idx < 0) init_idx = i;
      if (i == int_off) INT = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (spi_wrt !== 1'b0) begin n_bad++; $display("FAIL reset_wrt got %b want 0", spi_wrt); end
    n_cmp++; if (spi_wrt_data !== 16'h0) begin n_bad++; $display("FAIL reset_wrt_data got %h want 0000", spi_wrt_data); end
    n_cmp++; if (yaw_rt !== 16'h0) begin n_bad++; $display("FAIL reset_yaw got %h want 0000", yaw_rt); end
    n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld got %b want 0", vld); end
    n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL reset_init_done got %b want 0", init_done); end
    rst = 1'b0;
  endtask

  task automatic test_init(input string tag);
    int          exp_i [3];
    logic [15:0] exp_d [3];
    int          gi;
    logic [15:0] gd;
    exp_i = '{15, 56, 97};
    exp_d = '{16'h0D02, 16'h1160, 16'h1440};
    run_cycles(200, -1);
    n_cmp++; if (wrt_idx.size() != 3) begin n_bad++; $display("FAIL %s_wrt_count got %0d want 3", tag, wrt_idx.size()); end
    for (int k = 0; k < 3; k++) begin
      gi = (wrt_idx.size() > k) ? wrt_idx[k] : -1;
      gd = (wrt_dat.size() > k) ? wrt_dat[k] : 16'hxxxx;
      n_cmp++;
      if (gi != exp_i[k] || gd !== exp_d[k]) begin
        n_bad++; $display("FAIL %s_wrt%0d got cyc %0d data %h want cyc %0d data %h", tag, k, gi, gd, exp_i[k], exp_d[k]);
      end
    end
    n_cmp++; if (init_idx != 138) begin n_bad++; $display("FAIL %s_init_done_cyc got %0d want 138", tag, init_idx); end
    n_cmp++; if (vld_idx.size() != 0) begin n_bad++; $display("FAIL %s_no_vld got %0d pulses want 0", tag, vld_idx.size()); end
  endtask

  task automatic test_read_pair(input string tag, input logic [15:0] exp_yaw);
    int          gi [2];
    logic [15:0] gd [2];
    INT = 1'b1;
    run_cycles(150, 1);
    for (int k = 0; k < 2; k++) begin
      gi[k] = (wrt_idx.size() > k) ? wrt_idx[k] : -1;
      gd[k] = (wrt_dat.size() > k) ? wrt_dat[k] : 16'hxxxx;
    end
    n_cmp++; if (wrt_idx.size() != 2) begin n_bad++; $display("FAIL %s_wrt_count got %0d want 2", tag, wrt_idx.size()); end
    n_cmp++; if (gi[0] != 2 || gd[0] !== 16'hA600) begin n_bad++; $display("FAIL %s_rd_l got cyc %0d data %h want cyc 2 data a600", tag, gi[0], gd[0]); end
    n_cmp++; if (gi[1] != 43 || gd[1] !== 16'hA700) begin n_bad++; $display("FAIL %s_rd_h got cyc %0d data %h want cyc 43 data a700", tag, gi[1], gd[1]); end
    n_cmp++; if (vld_idx.size() != 1) begin n_bad++; $display("FAIL %s_vld_count got %0d want 1", tag, vld_idx.size()); end
    else begin
      n_cmp++; if (vld_idx[0] != 84) begin n_bad++; $display("FAIL %s_vld_cyc got %0d want 84", tag, vld_idx[0]); end
      n_cmp++; if (vld_yaw[0] !== exp_yaw) begin n_bad++; $display("FAIL %s_yaw got %h want %h", tag, vld_yaw[0], exp_yaw); end
    end
  endtask

  task automatic test_back_to_back();
    int          exp_i [4];
    logic [15:0] exp_d [4];
    int          exp_v [2];
    exp_i = '{2, 43, 84, 125};
    exp_d = '{16'hA600, 16'hA700, 16'hA600, 16'hA700};
    exp_v = '{84, 166};
    lo_val = 8'h34; hi_val = 8'h12; upper = 8'hC3;
    INT = 1'b1;
    run_cycles(260, 100);
    n_cmp++; if (wrt_idx.size() != 4) begin n_bad++; $display("FAIL b2b_wrt_count got %0d want 4", wrt_idx.size()); end
    else for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (wrt_idx[k] != exp_i[k] || wrt_dat[k] !== exp_d[k]) begin
        n_bad++; $display("FAIL b2b_wrt%0d got cyc %0d data %h want cyc %0d data %h", k, wrt_idx[k], wrt_dat[k], exp_i[k], exp_d[k]);
      end
    end
    n_cmp++; if (vld_idx.size() != 2) begin n_bad++; $display("FAIL b2b_vld_count got %0d want 2", vld_idx.size()); end
    else for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (vld_idx[k] != exp_v[k] || vld_yaw[k] !== 16'h1234) begin
        n_bad++; $display("FAIL b2b_vld%0d got cyc %0d yaw %h want cyc %0d yaw 1234", k, vld_idx[k], vld_yaw[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    lo_val = 8'h55; hi_val = 8'hAA; upper = 8'h00;
    INT = 1'b1;
    run_cycles(79, 1);
    n_cmp++; if (wrt_idx.size() != 2) begin n_bad++; $display("FAIL midrst_pre_wrt_count got %0d want 2", wrt_idx.size()); end
    rst = 1'b1;
    #1;
    n_cmp++; if (spi_wrt !== 1'b0) begin n_bad++; $display("FAIL midrst_wrt got %b want 0", spi_wrt); end
    n_cmp++; if (spi_wrt_data !== 16'h0) begin n_bad++; $display("FAIL midrst_wrt_data got %h want 0000", spi_wrt_data); end
    n_cmp++; if (yaw_rt !== 16'h0) begin n_bad++; $display("FAIL midrst_yaw got %h want 0000", yaw_rt); end
    n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL midrst_vld got %b want 0", vld); end
    n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL midrst_init_done got %b want 0", init_done); end
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    test_init("reinit");
  endtask

`ifdef IMU_INT_TIMEOUT_EN
  task automatic test_timeout();
    INT = 1'b0;
    run_cycles(200, -1);
    n_cmp++; if (int_to !== 1'b1) begin n_bad++; $display("FAIL to_flag got %b want 1", int_to); end
    n_cmp++; if (wrt_idx.size() < 1 || wrt_idx[0] != 66) begin n_bad++; $display("FAIL to_forced_wrt got %0d wrts want first at cyc 66", wrt_idx.size()); end
    n_cmp++; if (vld_idx.size() != 1 || vld_yaw[0] !== 16'hAA55) begin n_bad++; $display("FAIL to_forced_vld got %0d pulses want 1 with yaw aa55", vld_idx.size()); end
    INT = 1'b1;
    run_cycles(4, 1);
    n_cmp++; if (int_to !== 1'b0) begin n_bad++; $display("FAIL to_clear got %b want 0", int_to); end
  endtask
`endif

  initial begin
    test_reset();
    test_init("init");
    lo_val = 8'hB4; hi_val = 8'hFF; upper = 8'h00;
    test_read_pair("read", 16'hFFB4);
    stale_hold = 5; lo_val = 8'h01; hi_val = 8'h80; upper = 8'hC3;
    test_read_pair("stale", 16'h8001);
    stale_hold = 0;
    test_back_to_back();
    test_reset_mid_frame();
`ifdef IMU_INT_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
